// File: rtl/result_writeback_pkg.sv
// Shared types for the calc core result path: lane geometry, FIFO entry layout
// and the two-beat serialiser state.
package calc_pkg;

    localparam int LANES      = 8;
    localparam int LANE_W     = 16;
    localparam int BEAT_LANES = 4;
    localparam int BEATS      = 2;

    typedef logic [LANES-1:0][LANE_W-1:0]      result_vec_t;
    typedef logic [BEAT_LANES-1:0][LANE_W-1:0] beat_vec_t;

    typedef struct packed {
        logic [31:0] addr;
        result_vec_t data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        BEAT0 = 1'b0,
        BEAT1 = 1'b1
    } beat_e;

endpackage

// File: rtl/result_writeback_if.sv
// Result-vector input handshake plus the B-memory write-beat port.
interface result_writeback_if;
    import calc_pkg::*;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_addr;
    result_vec_t res_data;

    logic        mem_wr_en;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_addr;
    beat_vec_t   mem_wr_data;

    // The writeback block is the slave of the result stream and drives memory writes.
    modport slave (
        input  res_valid, res_addr, res_data, mem_wr_ready,
        output res_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport master (
        output res_valid, res_addr, res_data, mem_wr_ready,
        input  res_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/result_writeback_fifo.sv
// Synchronous FIFO of writeback entries; registered storage, head read combinationally.
module wb_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t wr_entry,
    input  logic      pop,
    output wb_entry_t rd_entry,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; occupancy gates every read, so stale
    // contents are never observed and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/result_writeback.sv
// Buffers 8-lane result vectors and writes each to B memory as two 64-bit beats.
module result_writeback
    import calc_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_STRIDE = 8,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    result_writeback_if.slave bus,
    output logic [CNT_W-1:0] wr_count,
    output logic             idle
);

    wb_entry_t in_entry;
    wb_entry_t head;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      xfer;
    beat_e     beat;
    beat_e     beat_next;

    assign in_entry      = '{addr: bus.res_addr, data: bus.res_data};
    assign bus.res_ready = !full;
    assign push          = bus.res_valid && !full;
    assign bus.mem_wr_en = !empty;
    assign xfer          = !empty && bus.mem_wr_ready;
    assign idle          = empty && (beat == BEAT0);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wr_entry (in_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (full),
        .empty    (empty)
    );

    // NOTE: state and counters use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat     <= BEAT0;
            wr_count <= '0;
        end else begin
            beat <= beat_next;
            if (pop) wr_count <= wr_count + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        beat_next       = beat;
        pop             = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        if (!empty) begin
            case (beat)
                BEAT0: begin
                    bus.mem_wr_addr = head.addr;
                    bus.mem_wr_data = head.data[BEAT_LANES-1:0];
                    if (xfer) beat_next = BEAT1;
                end
                BEAT1: begin
                    bus.mem_wr_addr = head.addr + 32'(ADDR_STRIDE);
                    bus.mem_wr_data = head.data[LANES-1:BEAT_LANES];
                    if (xfer) begin
                        beat_next = BEAT0;
                        pop       = 1'b1;
                    end
                end
                default: beat_next = BEAT0;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: expected beats queued on each accepted
// vector and compared against every write beat presented to memory.
module tb_result_writeback;
    import calc_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        bit          last;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] wr_count;
    logic             idle;

    result_writeback_if bus ();

    result_writeback #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ADDR_STRIDE (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .wr_count (wr_count),
        .idle     (idle)
    );

    int               total = 0;
    int               bad   = 0;
    beat_t            sb[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: compares state each cycle, then applies the handshakes of the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("wr_count", 64'(wr_count), 64'(exp_cnt));
            check("idle", 64'(idle), 64'(sb.size() == 0));
            check("res_ready", 64'(bus.res_ready), 64'(((sb.size() + 1) / 2) < FIFO_DEPTH));
            check("mem_wr_en", 64'(bus.mem_wr_en), 64'(sb.size() != 0));
            if (bus.mem_wr_en && sb.size() != 0) begin
                check("beat_addr", 64'(bus.mem_wr_addr), 64'(sb[0].addr));
                check("beat_data", 64'(bus.mem_wr_data), sb[0].data);
                if (bus.mem_wr_ready) begin
                    if (sb[0].last) exp_cnt++;
                    void'(sb.pop_front());
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                logic [127:0] v;
                v = bus.res_data;
                sb.push_back('{addr: bus.res_addr,         data: v[63:0],   last: 1'b0});
                sb.push_back('{addr: bus.res_addr + 32'd8, data: v[127:64], last: 1'b1});
            end
        end
    end

    task automatic push_vec(input logic [31:0] addr, input logic [127:0] data);
        logic acc;
        acc = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_addr  = addr;
        bus.res_data  = data;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.res_ready;
            @(posedge clk);
            #2;
        end
        check("push_accept", 64'(acc), 64'd1);
        bus.res_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = idle;
        end
        check("drain_idle", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [127:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] v;
        int           gaps;
        logic         seen;

        rst_n            = 1'b0;
        bus.res_valid    = 1'b0;
        bus.res_addr     = '0;
        bus.res_data     = '0;
        bus.mem_wr_ready = 1'b0;

        #12;
        check("rst_en", 64'(bus.mem_wr_en), 64'd0);
        check("rst_cnt", 64'(wr_count), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_ready", 64'(bus.res_ready), 64'd1);
        check("rst_addr", 64'(bus.mem_wr_addr), 64'd0);
        check("rst_data", 64'(bus.mem_wr_data), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single vector: beat 0 appears the cycle after the push, beat 1 next.
        bus.mem_wr_ready = 1'b1;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(i + 1);
        push_vec(32'h100, v);
        @(negedge clk);
        check("single_b0_en", 64'(bus.mem_wr_en), 64'd1);
        check("single_b0_addr", 64'(bus.mem_wr_addr), 64'h100);
        check("single_b0_data", 64'(bus.mem_wr_data), 64'h0004_0003_0002_0001);
        @(negedge clk);
        check("single_b1_addr", 64'(bus.mem_wr_addr), 64'h108);
        check("single_b1_data", 64'(bus.mem_wr_data), 64'h0008_0007_0006_0005);
        wait_idle();
        check("single_cnt", 64'(wr_count), 64'd1);

        // Back-pressure: beat 0 held for five cycles, monitor verifies stability.
        do_reset();
        bus.mem_wr_ready = 1'b0;
        push_vec(32'h2000, rand_vec());
        repeat (5) @(negedge clk);
        check("bp_hold_en", 64'(bus.mem_wr_en), 64'd1);
        check("bp_hold_addr", 64'(bus.mem_wr_addr), 64'h2000);
        @(posedge clk);
        #2;
        bus.mem_wr_ready = 1'b1;
        wait_idle();
        check("bp_cnt", 64'(wr_count), 64'd1);

        // Fill: four vectors fill the FIFO, a fifth is refused until dropped.
        do_reset();
        bus.mem_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_vec(32'h4000 + 32'(i * 16), rand_vec());
        @(negedge clk);
        check("fill_full", 64'(bus.res_ready), 64'd0);
        bus.res_valid = 1'b1;
        bus.res_addr  = 32'h5000;
        bus.res_data  = rand_vec();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fill_stall", 64'(bus.res_ready), 64'd0);
        end
        @(posedge clk);
        #2;
        bus.res_valid    = 1'b0;
        bus.mem_wr_ready = 1'b1;
        wait_idle();
        check("fill_cnt", 64'(wr_count), 64'd4);

        // Streaming: ten vectors drain with no bubble on mem_wr_en.
        do_reset();
        bus.mem_wr_ready = 1'b1;
        gaps = 0;
        seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) push_vec(32'h8000 + 32'(i * 16), rand_vec());
            end
            begin
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    seen = bus.mem_wr_en;
                end
                check("stream_start", 64'(seen), 64'd1);
                for (int i = 1; i < 20; i++) begin
                    @(negedge clk);
                    if (!bus.mem_wr_en) gaps++;
                end
            end
        join
        check("stream_gaps", 64'(gaps), 64'd0);
        wait_idle();
        check("stream_cnt", 64'(wr_count), 64'd10);

        // Address wrap across 2^32 for beat 1.
        do_reset();
        bus.mem_wr_ready = 1'b1;
        push_vec(32'hFFFF_FFFC, rand_vec());
        @(negedge clk);
        check("wrap_b0_addr", 64'(bus.mem_wr_addr), 64'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_b1_addr", 64'(bus.mem_wr_addr), 64'h0000_0004);
        wait_idle();

        // Reset mid-burst: head in BEAT1 with three vectors queued.
        do_reset();
        bus.mem_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_vec(32'hA000 + 32'(i * 16), rand_vec());
        bus.mem_wr_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.mem_wr_ready = 1'b0;
        @(negedge clk);
        check("mid_beat1_addr", 64'(bus.mem_wr_addr), 64'hA008);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = '0;
        #1;
        check("mid_rst_en", 64'(bus.mem_wr_en), 64'd0);
        check("mid_rst_cnt", 64'(wr_count), 64'd0);
        check("mid_rst_ready", 64'(bus.res_ready), 64'd1);
        check("mid_rst_idle", 64'(idle), 64'd1);
        check("mid_rst_addr", 64'(bus.mem_wr_addr), 64'd0);
        @(posedge clk);
        #2;
        rst_n            = 1'b1;
        bus.mem_wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(bus.mem_wr_en), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
